gf180mcu_fd_sc_mcu9t5v0__dffnq_chain_bist: RTL and testbench

Built-in self-test driver/checker for a chain of falling-edge D flip-flops (`dffnq` cells, `CLKN` tied to `CLK`). It drives an LFSR pattern into the chain's first `D` and compares the last `Q` against a delayed copy of what it launched. It reports a pass/fail verdict, a saturating error count and the first failing index. It sits directly upstream of the flop chain and consumes the chain output on the same clock.

---
 rtl/gf180mcu_fd_sc_mcu9t5v0__dffnq_chain_bist_pkg.sv | 21 ++
 rtl/gf180mcu_fd_sc_mcu9t5v0__bist_lfsr8.sv | 18 +
 rtl/gf180mcu_fd_sc_mcu9t5v0__dffnq_chain_bist.sv | 107 ++++++++++
 tb/tb_gf180mcu_fd_sc_mcu9t5v0__dffnq_chain_bist.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__dffnq_chain_bist_pkg.sv
// Shared types and constants for the dffnq chain BIST driver/checker.
package gf180mcu_fd_sc_mcu9t5v0__dffnq_chain_bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FLUSH,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } bist_state_t;

  // x^8+x^6+x^5+x^4+1 as feedback taps on q[7],q[5],q[4],q[3]
  localparam logic [7:0]  LFSR_TAPS = 8'hB8;
  localparam logic [7:0]  ERR_SAT   = 8'hFF;
  localparam logic [15:0] NO_ERR    = 16'hFFFF;

  function automatic logic lfsr_fb(input logic [7:0] s);
    return ^(s & LFSR_TAPS);
  endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__bist_lfsr8.sv
// 8-bit Fibonacci LFSR, MSB-first output, with seed load and shift enable.
module gf180mcu_fd_sc_mcu9t5v0__bist_lfsr8
  import gf180mcu_fd_sc_mcu9t5v0__dffnq_chain_bist_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       shift,
  input  logic [7:0] seed,
  output logic [7:0] q
);

  always_ff @(posedge clk) begin
    if (rst || load) q <= seed;
    else if (shift)  q <= {q[6:0], lfsr_fb(q)};
  end

endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__dffnq_chain_bist.sv
// BIST for a falling-edge flop chain: launches an LFSR pattern into CHAIN_D and
// checks CHAIN_Q against a CHAIN_LEN-deep delayed copy of the launched bits.
module gf180mcu_fd_sc_mcu9t5v0__dffnq_chain_bist
  import gf180mcu_fd_sc_mcu9t5v0__dffnq_chain_bist_pkg::*;
#(
  parameter int         CHAIN_LEN = 8,
  parameter int         PAT_LEN   = 255,
  parameter logic [7:0] SEED      = 8'hA5
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic        CHAIN_Q,
  output logic        CHAIN_D,
  output logic        BUSY,
  output logic        DONE,
  output logic        PASS,
  output logic [7:0]  ERR_CNT,
  output logic [15:0] FIRST_ERR
);

  localparam logic [15:0] CL_LAST = 16'(CHAIN_LEN - 1);
  localparam logic [15:0] PL_LAST = 16'(PAT_LEN - 1);

  bist_state_t          state, state_nxt;
  logic [15:0]          phase, cmp_idx;
  logic [7:0]           lfsr;
  logic [CHAIN_LEN-1:0] exp_pipe, vld_pipe;
  logic                 clear, launch, push_bit, cmp_en, mismatch;

  // IDLE continuously re-arms; DONE re-arms only when a new run is requested
  assign clear    = (state == ST_IDLE) || (state == ST_DONE && START);
  assign launch   = (state == ST_RUN);
  assign push_bit = launch & lfsr[7];

  gf180mcu_fd_sc_mcu9t5v0__bist_lfsr8 u_lfsr (
    .clk  (CLK),
    .rst  (RST),
    .load (clear),
    .shift(launch),
    .seed (SEED),
    .q    (lfsr)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (START)             state_nxt = ST_FLUSH;
      ST_FLUSH: if (phase == CL_LAST)  state_nxt = ST_RUN;
      ST_RUN:   if (phase == PL_LAST)  state_nxt = ST_DRAIN;
      ST_DRAIN: if (phase == CL_LAST)  state_nxt = ST_DONE;
      ST_DONE:  if (START)             state_nxt = ST_FLUSH;
      default:                         state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= ST_IDLE;
      phase <= '0;
    end else begin
      state <= state_nxt;
      phase <= (state_nxt != state || state == ST_IDLE || state == ST_DONE)
               ? '0 : phase + 16'd1;
    end
  end

  // Launch flop and expected/valid delay lines; zeros flow in outside RUN
  always_ff @(posedge CLK) begin
    if (RST) begin
      CHAIN_D  <= 1'b0;
      exp_pipe <= '0;
      vld_pipe <= '0;
    end else begin
      CHAIN_D <= push_bit;
      for (int i = CHAIN_LEN - 1; i > 0; i--) begin
        exp_pipe[i] <= exp_pipe[i-1];
        vld_pipe[i] <= vld_pipe[i-1];
      end
      exp_pipe[0] <= push_bit;
      vld_pipe[0] <= launch;
    end
  end

  // A valid bit at the tail marks a launched bit now due at CHAIN_Q
  assign cmp_en   = vld_pipe[CHAIN_LEN-1] && (state == ST_RUN || state == ST_DRAIN);
  assign mismatch = CHAIN_Q ^ exp_pipe[CHAIN_LEN-1];

  always_ff @(posedge CLK) begin
    if (RST || clear) begin
      ERR_CNT   <= '0;
      FIRST_ERR <= NO_ERR;
      cmp_idx   <= '0;
    end else if (cmp_en) begin
      cmp_idx <= cmp_idx + 16'd1;
      if (mismatch) begin
        if (ERR_CNT != ERR_SAT)  ERR_CNT   <= ERR_CNT + 8'd1;
        if (FIRST_ERR == NO_ERR) FIRST_ERR <= cmp_idx;
      end
    end
  end

  assign BUSY = (state == ST_FLUSH) || (state == ST_RUN) || (state == ST_DRAIN);
  assign DONE = (state == ST_DONE);
  assign PASS = DONE && (ERR_CNT == 8'd0);

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__dffnq_chain_bist.sv
// Three BIST instances, each driving a behavioural falling-edge chain:
// [0] 8/255 with selectable faults, [1] 8/300 inverted output, [2] 1/1 golden.
module tb_gf180mcu_fd_sc_mcu9t5v0__dffnq_chain_bist;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  start = '0;
  logic [2:0]  chain_q, chain_d, busy, done, pass;
  logic [7:0]  err_cnt   [3];
  logic [15:0] first_err [3];

  int checks = 0;
  int errors = 0;
  int mode_a = 0;  // 0 golden, 1 stuck-at-0 stage 4, 2 seven stages

  logic [7:0] ch_a = '0, ch_b = '0, nx_a;
  logic       ch_c = 1'b0;

  always #5 clk = ~clk;

  gf180mcu_fd_sc_mcu9t5v0__dffnq_chain_bist #(.CHAIN_LEN(8), .PAT_LEN(255), .SEED(8'hA5)) u_a (
    .CLK(clk), .RST(rst), .START(start[0]), .CHAIN_Q(chain_q[0]), .CHAIN_D(chain_d[0]),
    .BUSY(busy[0]), .DONE(done[0]), .PASS(pass[0]), .ERR_CNT(err_cnt[0]), .FIRST_ERR(first_err[0]));

  gf180mcu_fd_sc_mcu9t5v0__dffnq_chain_bist #(.CHAIN_LEN(8), .PAT_LEN(300), .SEED(8'hA5)) u_b (
    .CLK(clk), .RST(rst), .START(start[1]), .CHAIN_Q(chain_q[1]), .CHAIN_D(chain_d[1]),
    .BUSY(busy[1]), .DONE(done[1]), .PASS(pass[1]), .ERR_CNT(err_cnt[1]), .FIRST_ERR(first_err[1]));

  gf180mcu_fd_sc_mcu9t5v0__dffnq_chain_bist #(.CHAIN_LEN(1), .PAT_LEN(1), .SEED(8'hA5)) u_c (
    .CLK(clk), .RST(rst), .START(start[2]), .CHAIN_Q(chain_q[2]), .CHAIN_D(chain_d[2]),
    .BUSY(busy[2]), .DONE(done[2]), .PASS(pass[2]), .ERR_CNT(err_cnt[2]), .FIRST_ERR(first_err[2]));

  // Behavioural dffnq chains
  always @(negedge clk) begin
    nx_a = {ch_a[6:0], chain_d[0]};
    if (mode_a == 1) nx_a[3] = 1'b0;
    ch_a <= nx_a;
    ch_b <= {ch_b[6:0], chain_d[1]};
    ch_c <= chain_d[2];
  end
  assign chain_q[0] = (mode_a == 2) ? ch_a[6] : ch_a[7];
  assign chain_q[1] = ~ch_b[7];
  assign chain_q[2] = ch_c;

  function automatic int cl_of(input int w);
    return (w == 2) ? 1 : 8;
  endfunction

  function automatic int pl_of(input int w);
    return (w == 1) ? 300 : ((w == 2) ? 1 : 255);
  endfunction

  // Reference: list of launched bits, then what each fault makes the chain return
  function automatic void model(input int w, input int mode, output int ecnt, output int ferr);
    int b[$];
    int s, pl, obs;
    pl = pl_of(w);
    s  = 'hA5;
    for (int i = 0; i < pl; i++) begin
      b.push_back((s >> 7) & 1);
      s = ((s << 1) | (((s >> 7) ^ (s >> 5) ^ (s >> 4) ^ (s >> 3)) & 1)) & 255;
    end
    b.push_back(0);
    ecnt = 0;
    ferr = 'hFFFF;
    for (int i = 0; i < pl; i++) begin
      case (mode)
        0:       obs = b[i];
        1:       obs = 0;
        2:       obs = b[i+1];
        default: obs = 1 - b[i];
      endcase
      if (obs != b[i]) begin
        if (ferr == 'hFFFF) ferr = i;
        if (ecnt < 255) ecnt++;
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_run(input int w, input int hold, input int mode);
    int len, ecnt, ferr, explen;
    logic [7:0] pat;
    pat = 8'hA5;
    if (w == 0) mode_a = mode;
    model(w, (w == 1) ? 3 : mode, ecnt, ferr);
    explen = 2 * cl_of(w) + pl_of(w);
    repeat ($urandom_range(0, 4)) @(posedge clk);
    @(posedge clk); #1;
    start[w] = 1'b1;
    @(posedge clk); #1;
    chk("busy_rise", 32'(busy[w]), 32'd1);
    chk("cleared_err_cnt", 32'(err_cnt[w]), 32'd0);
    chk("cleared_first_err", 32'(first_err[w]), 32'hFFFF);
    len = 0;
    while (busy[w] && len < explen + 50) begin
      if (len == hold) start[w] = 1'b0;
      len++;
      @(posedge clk); #1;
      if (w != 2 && len >= 9 && len <= 16)
        chk("launch_bit", 32'(chain_d[w]), 32'(pat[16-len]));
    end
    start[w] = 1'b0;
    chk("busy_len", len, explen);
    chk("done", 32'(done[w]), 32'd1);
    chk("pass", 32'(pass[w]), 32'(ecnt == 0));
    chk("err_cnt", 32'(err_cnt[w]), ecnt);
    chk("first_err", 32'(first_err[w]), ferr);
    repeat (3) @(posedge clk); #1;
    chk("done_hold", 32'(done[w]), 32'd1);
    chk("err_cnt_hold", 32'(err_cnt[w]), ecnt);
  endtask

  task automatic reset_mid(input int at);
    mode_a = 1;
    @(posedge clk); #1;
    start[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    repeat (at) @(posedge clk); #1;
    chk("mid_busy", 32'(busy[0]), 32'd1);
    chk("mid_first_err", 32'(first_err[0]), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_chain_d", 32'(chain_d[0]), 32'd0);
    chk("rst_busy", 32'(busy[0]), 32'd0);
    chk("rst_first_err", 32'(first_err[0]), 32'hFFFF);
    chk("rst_err_cnt", 32'(err_cnt[0]), 32'd0);
    rst = 1'b0;
    do_run(0, 0, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk); #1;
    for (int w = 0; w < 3; w++) begin
      chk("reset_chain_d", 32'(chain_d[w]), 32'd0);
      chk("reset_busy", 32'(busy[w]), 32'd0);
      chk("reset_done", 32'(done[w]), 32'd0);
      chk("reset_pass", 32'(pass[w]), 32'd0);
      chk("reset_err_cnt", 32'(err_cnt[w]), 32'd0);
      chk("reset_first_err", 32'(first_err[w]), 32'hFFFF);
    end
    rst = 1'b0;

    do_run(0, 0, 0);    // golden
    do_run(0, 0, 1);    // stuck-at-0, restart from DONE
    do_run(0, 0, 2);    // short chain
    do_run(0, 100, 0);  // START held into RUN
    do_run(1, 0, 3);    // saturation
    do_run(2, 0, 0);    // minimal lengths
    reset_mid(20);
    reset_mid($urandom_range(21, 260));
    for (int k = 0; k < 4; k++)
      do_run(0, $urandom_range(0, 150), $urandom_range(0, 2));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
